// File: rtl/fofb_setpoint_streamer.sv
// FOFB setpoint streamer: double-buffered per-channel setpoint bank, written by the CPU through
// strobed GPIO, streamed as one AXI-Stream frame of CHANNEL_COUNT words per FOFB trigger.
// Optional output clamp enabled by defining SETPOINT_CLIP_EN.
module fofb_setpoint_streamer #(
  parameter int unsigned        CHANNEL_COUNT  = 24,
  parameter logic signed [31:0] SETPOINT_LIMIT = 32'sd524287
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] GPIO_OUT,
  input  logic        csrStrobe,
  input  logic        indexStrobe,
  input  logic        dataStrobe,
  input  logic        commitStrobe,
  input  logic        fofbTrigger,
  output logic [31:0] status,
  output logic        M_AXIS_TVALID,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic [7:0]  M_AXIS_TUSER,
  input  logic        M_AXIS_TREADY
);

  localparam int unsigned IdxW    = $clog2(CHANNEL_COUNT);
  localparam logic [7:0]  LastIdx = 8'(CHANNEL_COUNT - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e      state_q, state_d;
  logic [31:0] shadow_q [CHANNEL_COUNT];
  logic [31:0] shadow_d [CHANNEL_COUNT];
  logic [31:0] active_q [CHANNEL_COUNT];
  logic [31:0] active_d [CHANNEL_COUNT];
  logic [7:0]  wr_idx_q, wr_idx_d;
  logic        enable_q, enable_d;
  logic        commit_pending_q, commit_pending_d;
  logic        clip_flag_q, clip_flag_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [15:0] overrun_cnt_q, overrun_cnt_d;
  logic        tvalid_q, tvalid_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tlast_q, tlast_d;
  logic [7:0]  tuser_q, tuser_d;

  logic        handshake;
  logic        last_handshake;
  logic        load_en;
  logic [31:0] raw_word;
  logic [31:0] out_word;
  logic        clip_hit;
  logic [7:0]  next_idx;

  // Output word conditioning: optional symmetric clamp at the output register.
`ifdef SETPOINT_CLIP_EN
  localparam logic signed [31:0] NegLimit = -SETPOINT_LIMIT;

  always_comb begin
    out_word = raw_word;
    clip_hit = 1'b0;
    if ($signed(raw_word) > SETPOINT_LIMIT) begin
      out_word = SETPOINT_LIMIT;
      clip_hit = 1'b1;
    end else if ($signed(raw_word) < NegLimit) begin
      out_word = NegLimit;
      clip_hit = 1'b1;
    end
  end
`else
  logic unused_limit;
  assign unused_limit = ^SETPOINT_LIMIT;

  always_comb begin
    out_word = raw_word;
    clip_hit = 1'b0;
  end
`endif

  // Next-state logic for CPU bank access, frame sequencing and counters.
  always_comb begin
    state_d          = state_q;
    shadow_d         = shadow_q;
    active_d         = active_q;
    wr_idx_d         = wr_idx_q;
    enable_d         = enable_q;
    commit_pending_d = commit_pending_q;
    clip_flag_d      = clip_flag_q;
    frame_cnt_d      = frame_cnt_q;
    overrun_cnt_d    = overrun_cnt_q;
    tvalid_d         = tvalid_q;
    tdata_d          = tdata_q;
    tlast_d          = tlast_q;
    tuser_d          = tuser_q;
    load_en          = 1'b0;
    raw_word         = '0;
    next_idx         = tuser_q + 8'd1;
    handshake        = tvalid_q && M_AXIS_TREADY;
    last_handshake   = handshake && tlast_q;

    // Shadow write uses the old index; a simultaneous index load overrides the increment.
    if (dataStrobe) begin
      shadow_d[wr_idx_q[IdxW-1:0]] = GPIO_OUT;
      wr_idx_d = (wr_idx_q == LastIdx) ? 8'd0 : wr_idx_q + 8'd1;
    end
    if (indexStrobe) begin
      wr_idx_d = (GPIO_OUT[7:0] > LastIdx) ? 8'd0 : GPIO_OUT[7:0];
    end

    // Commits are deferred while streaming so a frame never mixes banks.
    if (commitStrobe) begin
      if (state_q == StIdle) begin
        active_d = shadow_q;
      end else begin
        commit_pending_d = 1'b1;
      end
    end
    if (last_handshake && (commit_pending_q || commitStrobe)) begin
      active_d         = shadow_q;
      commit_pending_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (fofbTrigger && enable_q) begin
          state_d  = StStream;
          tvalid_d = 1'b1;
          tuser_d  = 8'd0;
          tlast_d  = (LastIdx == 8'd0);
          load_en  = 1'b1;
          // A commit in the trigger cycle takes effect for this frame.
          raw_word = commitStrobe ? shadow_q[0] : active_q[0];
        end
      end
      StStream: begin
        if (fofbTrigger) begin
          overrun_cnt_d = (overrun_cnt_q == 16'hFFFF) ? overrun_cnt_q : overrun_cnt_q + 16'd1;
        end
        if (handshake) begin
          if (tlast_q) begin
            state_d     = StIdle;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            tuser_d     = 8'd0;
            tdata_d     = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            tuser_d  = next_idx;
            tlast_d  = (next_idx == LastIdx);
            load_en  = 1'b1;
            raw_word = active_q[next_idx[IdxW-1:0]];
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_en) begin
      tdata_d = out_word;
      if (clip_hit) begin
        clip_flag_d = 1'b1;
      end
    end

    // Clear has priority over any increment in the same cycle.
    if (csrStrobe) begin
      enable_d = GPIO_OUT[31];
      if (GPIO_OUT[30]) begin
        frame_cnt_d   = '0;
        overrun_cnt_d = '0;
        clip_flag_d   = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      shadow_q         <= '{default: '0};
      active_q         <= '{default: '0};
      wr_idx_q         <= '0;
      enable_q         <= 1'b0;
      commit_pending_q <= 1'b0;
      clip_flag_q      <= 1'b0;
      frame_cnt_q      <= '0;
      overrun_cnt_q    <= '0;
      tvalid_q         <= 1'b0;
      tdata_q          <= '0;
      tlast_q          <= 1'b0;
      tuser_q          <= '0;
    end else begin
      state_q          <= state_d;
      shadow_q         <= shadow_d;
      active_q         <= active_d;
      wr_idx_q         <= wr_idx_d;
      enable_q         <= enable_d;
      commit_pending_q <= commit_pending_d;
      clip_flag_q      <= clip_flag_d;
      frame_cnt_q      <= frame_cnt_d;
      overrun_cnt_q    <= overrun_cnt_d;
      tvalid_q         <= tvalid_d;
      tdata_q          <= tdata_d;
      tlast_q          <= tlast_d;
      tuser_q          <= tuser_d;
    end
  end

  assign status = {enable_q, (state_q == StStream), commit_pending_q, clip_flag_q, 4'b0000,
                   frame_cnt_q, overrun_cnt_q};

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TUSER  = tuser_q;

endmodule

// File: tb/tb_fofb_setpoint_streamer.sv
// Directed bench for fofb_setpoint_streamer with hand-computed expectations.
module tb_fofb_setpoint_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] GPIO_OUT = '0;
  logic        csrStrobe = 1'b0;
  logic        indexStrobe = 1'b0;
  logic        dataStrobe = 1'b0;
  logic        commitStrobe = 1'b0;
  logic        fofbTrigger = 1'b0;
  logic [31:0] status;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic [7:0]  M_AXIS_TUSER;
  logic        M_AXIS_TREADY = 1'b1;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_bank [24];
  logic [31:0] clip_bit;

  fofb_setpoint_streamer #(
    .CHANNEL_COUNT (24),
    .SETPOINT_LIMIT(32'sd524287)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .GPIO_OUT     (GPIO_OUT),
    .csrStrobe    (csrStrobe),
    .indexStrobe  (indexStrobe),
    .dataStrobe   (dataStrobe),
    .commitStrobe (commitStrobe),
    .fofbTrigger  (fofbTrigger),
    .status       (status),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .M_AXIS_TUSER (M_AXIS_TUSER),
    .M_AXIS_TREADY(M_AXIS_TREADY)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_index(input logic [31:0] v);
    GPIO_OUT = v; indexStrobe = 1'b1; step(); indexStrobe = 1'b0;
  endtask

  task automatic write_data(input logic [31:0] v);
    GPIO_OUT = v; dataStrobe = 1'b1; step(); dataStrobe = 1'b0;
  endtask

  task automatic write_csr(input logic [31:0] v);
    GPIO_OUT = v; csrStrobe = 1'b1; step(); csrStrobe = 1'b0;
  endtask

  task automatic commit();
    commitStrobe = 1'b1; step(); commitStrobe = 1'b0;
  endtask

  // Start a frame; with_commit also pulses commit in the trigger cycle.
  task automatic trigger(input logic with_commit);
    fofbTrigger = 1'b1; commitStrobe = with_commit; step();
    fofbTrigger = 1'b0; commitStrobe = 1'b0;
  endtask

  // Checks all 24 beats of a frame already started; negative beat numbers disable an action.
  task automatic run_frame(input int stall_beat, input int stall_len, input int trig_beat,
                           input int commit_beat, input int csr_beat, input logic [31:0] csr_val);
    logic [63:0] beat;
    for (int b = 0; b < 24; b++) begin
      beat = {22'd0, 1'b1, (b == 23), 8'(b), exp_bank[b]};
      chk($sformatf("beat%0d", b), {22'd0, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER,
          M_AXIS_TDATA}, beat);
      if (b == 1) chk("busy", {63'd0, status[30]}, 64'd1);
      if (commit_beat >= 0 && b == commit_beat + 1) chk("pending", {63'd0, status[29]}, 64'd1);
      if (b == stall_beat) begin
        M_AXIS_TREADY = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          step();
          chk($sformatf("stall%0d", k), {22'd0, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER,
              M_AXIS_TDATA}, beat);
        end
        M_AXIS_TREADY = 1'b1;
      end
      if (b == trig_beat) fofbTrigger = 1'b1;
      if (b == commit_beat) commitStrobe = 1'b1;
      if (b == csr_beat) begin
        GPIO_OUT = csr_val; csrStrobe = 1'b1;
      end
      step();
      fofbTrigger = 1'b0; commitStrobe = 1'b0; csrStrobe = 1'b0;
    end
    chk("frame_end_tvalid", {63'd0, M_AXIS_TVALID}, 64'd0);
    chk("frame_end_pending", {63'd0, status[29]}, 64'd0);
  endtask

  initial begin
    #12;
    chk("rst_tvalid", {63'd0, M_AXIS_TVALID}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_status", {32'd0, status}, 64'h0);
    chk("idle_out", {22'd0, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TDATA}, 64'd0);

    // Load bank, commit in idle; trigger while disabled is ignored.
    set_index(32'd0);
    for (int i = 0; i < 24; i++) begin
      write_data(32'h100 + 32'(i));
      exp_bank[i] = 32'h100 + 32'(i);
    end
    commit();
    trigger(1'b0);
    chk("disabled_trig", {31'd0, M_AXIS_TVALID, status}, 64'h0);
    write_csr(32'h8000_0000);
    chk("enabled_status", {32'd0, status}, 64'h8000_0000);

    // Basic frame.
    trigger(1'b0);
    run_frame(-1, 0, -1, -1, -1, 32'd0);
    chk("status_f1", {32'd0, status}, 64'h8001_0000);

    // Backpressure at beat 5.
    trigger(1'b0);
    run_frame(5, 3, -1, -1, -1, 32'd0);
    chk("status_f2", {32'd0, status}, 64'h8002_0000);

    // Overrun at beat 10, deferred commit at beat 12.
    set_index(32'd0);
    write_data(32'h0000_DEAD);
    trigger(1'b0);
    run_frame(-1, 0, 10, 12, -1, 32'd0);
    chk("status_f3", {32'd0, status}, 64'h8003_0001);
    exp_bank[0] = 32'h0000_DEAD;

    // New bank visible; trigger on the final handshake is an overrun.
    trigger(1'b0);
    run_frame(-1, 0, 23, -1, -1, 32'd0);
    chk("status_f4", {32'd0, status}, 64'h8004_0002);

    // Commit in the trigger cycle applies to the new frame.
    set_index(32'd0);
    write_data(32'h0000_BEEF);
    exp_bank[0] = 32'h0000_BEEF;
    trigger(1'b1);
    run_frame(-1, 0, -1, -1, -1, 32'd0);
    chk("status_f5", {32'd0, status}, 64'h8005_0002);

    // Index wrap, out-of-range index, simultaneous index+data.
    set_index(32'd23);
    write_data(32'h123);
    write_data(32'h124);
    write_data(32'h125);
    set_index(32'd250);
    GPIO_OUT = 32'd3; indexStrobe = 1'b1; dataStrobe = 1'b1; step();
    indexStrobe = 1'b0; dataStrobe = 1'b0;
    write_data(32'h77);
    exp_bank[23] = 32'h123;
    exp_bank[0]  = 32'd3;
    exp_bank[1]  = 32'h125;
    exp_bank[3]  = 32'h77;
    commit();
    chk("commit_idle_pending", {63'd0, status[29]}, 64'd0);

    // Disable mid-frame: frame completes, later triggers ignored.
    trigger(1'b0);
    run_frame(-1, 0, -1, -1, 8, 32'h0000_0000);
    chk("status_f6", {32'd0, status}, 64'h0006_0002);
    trigger(1'b0);
    chk("disabled_again", {31'd0, M_AXIS_TVALID, status}, 64'h0006_0002);

    // Clear counters; clear wins over the frame increment on the last beat.
    write_csr(32'hC000_0000);
    chk("cleared", {32'd0, status}, 64'h8000_0000);
    trigger(1'b0);
    run_frame(-1, 0, -1, -1, 23, 32'hC000_0000);
    chk("clear_wins", {32'd0, status}, 64'h8000_0000);

    // Extreme values: clamped with the clip feature, passed through otherwise.
    set_index(32'd3);
    write_data(32'h7FFF_FFFF);
    write_data(32'h8000_0000);
    commit();
`ifdef SETPOINT_CLIP_EN
    exp_bank[3] = 32'h0007_FFFF;
    exp_bank[4] = 32'hFFF8_0001;
    clip_bit = 32'h1000_0000;
`else
    exp_bank[3] = 32'h7FFF_FFFF;
    exp_bank[4] = 32'h8000_0000;
    clip_bit = 32'h0;
`endif
    trigger(1'b0);
    run_frame(-1, 0, -1, -1, -1, 32'd0);
    chk("status_clip", {32'd0, status}, {32'd0, 32'h8001_0000 | clip_bit});
    write_csr(32'hC000_0000);
    chk("clip_cleared", {32'd0, status}, 64'h8000_0000);

    // Asynchronous reset at beat 7.
    trigger(1'b0);
    for (int b = 0; b < 7; b++) step();
    chk("pre_reset_beat", {56'd0, M_AXIS_TUSER}, 64'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", {22'd0, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TDATA}, 64'd0);
    chk("async_rst_status", {32'd0, status}, 64'h0);
    step();
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_rst_idle%0d", k), {31'd0, M_AXIS_TVALID, status}, 64'h0);
    end
    for (int i = 0; i < 24; i++) exp_bank[i] = 32'd0;
    write_csr(32'h8000_0000);
    trigger(1'b0);
    run_frame(-1, 0, -1, -1, -1, 32'd0);
    chk("status_after_rst", {32'd0, status}, 64'h8001_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
